mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM pipeline stage between EX and WB. Supports a multi-cycle data-memory handshake
//  (stalls until data_resp), byte/half/word load extraction with sign/zero extension, store-lane
//  alignment, misalignment flagging and downstream back-pressure. Registers MEM/WB state on posedge clk.
// PARAMETERS
//  XLEN    32  datapath/address width (multiple of 32)
//  MBE_W   XLEN/8  byte-enable width
//  CTRL_W  64  width of opaque control word passed through
//  TMO_CYC 255 watchdog limit in cycles (used only with MEM_STAGE_TIMEOUT_EN)
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst_n         in   1       reset; synchronous, active-low
//  in_valid      in   1       EX/MEM holds a valid instruction
//  pc_in         in   XLEN    instruction PC
//  instr_in      in   32      instruction word
//  ctrl_in       in   CTRL_W  control word, passed through
//  alu_in        in   XLEN    ALU result / effective address
//  rs2_in        in   XLEN    store data
//  br_en_in      in   1       branch compare result
//  mem_read_in   in   1       load
//  mem_write_in  in   1       store
//  funct3_in     in   3       size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  stall_in      in   1       WB/hazard unit back-pressure
//  data_rdata    in   XLEN    memory read data
//  data_resp     in   1       memory response (1 cycle per access)
//  data_addr     out  XLEN    {alu_in[XLEN-1:2],2'b00}
//  data_wdata    out  XLEN    store data replicated into lanes
//  data_mbe      out  MBE_W   byte enables shifted by alu_in[1:0]
//  data_read     out  1       read request
//  data_write    out  1       write request
//  stall_out     out  1       freeze PC/IF/ID/EX
//  out_valid     out  1       MEM/WB valid
//  pc_out, pc_plus4_out  out XLEN  registered PC, PC+4 (mod 2^XLEN)
//  instr_out     out  32; ctrl_out out CTRL_W; alu_out out XLEN   registered pass-through
//  rdata_out     out  XLEN    extended load result
//  br_en_out     out  XLEN    {XLEN-1 zeros, br_en}
//  misalign_out  out  1       registered misaligned-access flag
//  timeout_err   out  1       only with MEM_STAGE_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; every registered output 0; requests deasserted.
//  - misalign: H with addr[0]=1, or W with addr[1:0]!=0. A misaligned op issues no request, never
//    stalls, and propagates with misalign_out=1 and rdata_out=0.
//  - req = in_valid & (mem_read_in|mem_write_in) & ~misalign & state!=HOLD. data_read/data_write are
//    combinational from req; upstream holds inputs stable while stall_out=1.
//  - FSM: IDLE: req & ~data_resp -> WAIT; req & data_resp & stall_in -> HOLD (latch rdata).
//    WAIT: data_resp & ~stall_in -> IDLE; data_resp & stall_in -> HOLD. HOLD: ~stall_in -> IDLE.
//  - stall_out = stall_in | (req & ~data_resp) | (state==HOLD & stall_in).
//  - Zero-wait hit: req and data_resp same cycle -> no stall; result registered next posedge.
//  - Output register: stall_in=1 -> hold all; else if stall_out (memory wait) -> out_valid<=0 (bubble);
//    else load all fields, out_valid<=in_valid. Rdata source: HOLD latch if state==HOLD else data_rdata.
//  - Load extract: byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend, BU/HU zero-extend.
//  - Store: B -> mbe=0001<<addr[1:0], wdata={4{rs2[7:0]}}; H -> 0011<<addr[1:0], {2{rs2[15:0]}};
//    W -> 1111, rs2. mbe=0 when no store.
//  - Reset mid-access: FSM to IDLE, requests drop same cycle, latched rdata discarded.
// CONFIGURATION
//  MEM_STAGE_TIMEOUT_EN defined: counter counts cycles in WAIT; at TMO_CYC without data_resp, request
//    drops, FSM -> IDLE, instruction retires with rdata_out=0 and sticky timeout_err=1 (clear on reset).
//  Undefined: no counter, timeout_err port absent, WAIT persists indefinitely.
// TESTING
//  LW addr 0x100, resp same cycle, rdata 0xDEADBEEF -> stall_out never 1, rdata_out=0xDEADBEEF next edge.
//  LB addr 0x103, rdata 0x80FF_0000, resp after 3 cycles -> stall_out 3 cycles, 3 bubbles, rdata_out=0xFFFFFF80.
//  LHU addr 0x102, rdata 0x8001_1234 -> rdata_out=0x00008001; SB addr 0x101 rs2=0xAB -> mbe=0010, wdata=0xABABABAB.
//  LW addr 0x102 -> no data_read, no stall, misalign_out=1; resp during stall_in=1 -> HOLD keeps rdata across 2 stall cycles.
//  rst_n low while in WAIT -> data_read=0 same cycle, all outputs 0 next edge; timeout build: no resp 255 cycles -> timeout_err=1.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_hs_if
//  Purpose  : Bundle of the EX->MEM inputs, data-memory handshake and
//             MEM/WB outputs of the mem_stage_hs pipeline stage.
//  Modports : master - upstream / memory / testbench side (drives inputs)
//             slave  - the mem_stage_hs stage itself
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_hs_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 64
);
  localparam int MBE_W = XLEN / 8;

  // EX/MEM side
  logic              in_valid;
  logic [XLEN-1:0]   pc_in;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0]   alu_in;
  logic [XLEN-1:0]   rs2_in;
  logic              br_en_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [2:0]        funct3_in;
  logic              stall_in;

  // data-memory handshake
  logic [XLEN-1:0]   data_rdata;
  logic              data_resp;
  logic [XLEN-1:0]   data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic [MBE_W-1:0]  data_mbe;
  logic              data_read;
  logic              data_write;

  // hazard / MEM/WB side
  logic              stall_out;
  logic              out_valid;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   pc_plus4_out;
  logic [31:0]       instr_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [XLEN-1:0]   alu_out;
  logic [XLEN-1:0]   rdata_out;
  logic [XLEN-1:0]   br_en_out;
  logic              misalign_out;

  modport master (
    output in_valid, pc_in, instr_in, ctrl_in, alu_in, rs2_in, br_en_in,
           mem_read_in, mem_write_in, funct3_in, stall_in, data_rdata, data_resp,
    input  data_addr, data_wdata, data_mbe, data_read, data_write, stall_out,
           out_valid, pc_out, pc_plus4_out, instr_out, ctrl_out, alu_out,
           rdata_out, br_en_out, misalign_out
  );

  modport slave (
    input  in_valid, pc_in, instr_in, ctrl_in, alu_in, rs2_in, br_en_in,
           mem_read_in, mem_write_in, funct3_in, stall_in, data_rdata, data_resp,
    output data_addr, data_wdata, data_mbe, data_read, data_write, stall_out,
           out_valid, pc_out, pc_plus4_out, instr_out, ctrl_out, alu_out,
           rdata_out, br_en_out, misalign_out
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_hs
//  Purpose  : MEM pipeline stage between EX and WB. Issues a multi-cycle
//             data-memory request and stalls until data_resp, extracts and
//             extends byte/half/word loads, aligns store lanes, flags
//             misaligned accesses and honours WB back-pressure (stall_in).
//  Ports    : clk          - clock, all state on posedge
//             rst_n        - synchronous active-low reset
//             bus          - mem_stage_hs_if.slave (EX inputs, memory
//                            handshake, stall_out, MEM/WB registered outputs)
//             timeout_err  - sticky watchdog flag (MEM_STAGE_TIMEOUT_EN only)
//  Options  : MEM_STAGE_TIMEOUT_EN - adds a WAIT-state watchdog of TMO_CYC
//             cycles that abandons the access and raises timeout_err.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_hs #(
  parameter int XLEN    = 32,
  parameter int MBE_W   = XLEN / 8,
  parameter int CTRL_W  = 64,
  parameter int TMO_CYC = 255
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_stage_hs_if.slave bus
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   hold_q;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, pc4_q, alu_q, rdata_q;
  logic [31:0]       instr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              br_q, mis_q;

  logic              w_mem_op, w_size_b, w_size_h, w_size_w, w_sign, w_misalign;
  logic              w_req, w_stall, w_rd, w_wr, w_hold_ld, w_tmo;
  logic [MBE_W-1:0]  w_mbe;
  logic [XLEN-1:0]   w_wdata, w_src, w_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // ---------------------------------------------------------------- decode
  assign w_mem_op   = bus.mem_read_in | bus.mem_write_in;
  assign w_size_b   = (bus.funct3_in[1:0] == 2'b00);
  assign w_size_h   = (bus.funct3_in[1:0] == 2'b01);
  assign w_size_w   = bus.funct3_in[1];
  assign w_sign     = ~bus.funct3_in[2];
  assign w_misalign = w_mem_op &
                      ((w_size_h & bus.alu_in[0]) |
                       (w_size_w & (bus.alu_in[1:0] != 2'b00)));

  // ------------------------------------------------------------- watchdog
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;
  logic             w_tmo_hit;

  assign w_tmo_hit = (tmo_cnt_q == CNT_W'(TMO_CYC - 1));
  // Abandon only when WB can accept, so the retiring bubble-free result is
  // actually captured in the output register.
  assign w_tmo     = (state_q == S_WAIT) & ~bus.data_resp & ~bus.stall_in & w_tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && !bus.data_resp) begin
        if (!w_tmo_hit) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (w_tmo) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign w_tmo = 1'b0;
`endif

  // --------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (w_hold_ld) hold_q <= bus.data_rdata;
    end
  end

  // -------------------------------------------------------- next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_req && !bus.data_resp)                     state_d = S_WAIT;
        else if (w_req && bus.data_resp && bus.stall_in) state_d = S_HOLD;
      end
      S_WAIT: begin
        if (bus.data_resp) state_d = bus.stall_in ? S_HOLD : S_IDLE;
        else if (w_tmo)    state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!bus.stall_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ FSM outputs
  always_comb begin
    // No request in HOLD: the response is already latched.
    w_req     = bus.in_valid & w_mem_op & ~w_misalign & (state_q != S_HOLD) & ~w_tmo;
    // HOLD & stall_in is covered by the stall_in term.
    w_stall   = bus.stall_in | (w_req & ~bus.data_resp);
    // Requests drop in the same cycle reset is asserted.
    w_rd      = rst_n & w_req & bus.mem_read_in;
    w_wr      = rst_n & w_req & bus.mem_write_in;
    w_hold_ld = w_req & bus.data_resp & bus.stall_in;
  end

  // ----------------------------------------------------- store lane steering
  always_comb begin
    w_mbe   = '0;
    w_wdata = bus.rs2_in;
    if (w_size_b) begin
      w_wdata = {(XLEN/8){bus.rs2_in[7:0]}};
    end else if (w_size_h) begin
      w_wdata = {(XLEN/16){bus.rs2_in[15:0]}};
    end
    if (w_wr) begin
      if (w_size_b)      w_mbe = MBE_W'(1) << bus.alu_in[1:0];
      else if (w_size_h) w_mbe = MBE_W'(3) << bus.alu_in[1:0];
      else               w_mbe = MBE_W'(15);
    end
  end

  // ------------------------------------------------------ load extraction
  always_comb begin
    w_src = (state_q == S_HOLD) ? hold_q : bus.data_rdata;
    case (bus.alu_in[1:0])
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    w_half = bus.alu_in[1] ? w_src[31:16] : w_src[15:0];
    w_ext  = '0;
    // Misaligned, abandoned and non-load instructions retire with zero data.
    if (bus.mem_read_in && !w_misalign && !w_tmo) begin
      if (w_size_b)      w_ext = {{(XLEN-8){w_sign & w_byte[7]}}, w_byte};
      else if (w_size_h) w_ext = {{(XLEN-16){w_sign & w_half[15]}}, w_half};
      else               w_ext = w_src;
    end
  end

  // ------------------------------------------------------- MEM/WB register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      br_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!bus.stall_in) begin
      if (w_stall) begin
        valid_q <= 1'b0;                 // memory wait: insert a bubble
      end else begin
        valid_q <= bus.in_valid;
        pc_q    <= bus.pc_in;
        pc4_q   <= bus.pc_in + XLEN'(4);
        instr_q <= bus.instr_in;
        ctrl_q  <= bus.ctrl_in;
        alu_q   <= bus.alu_in;
        rdata_q <= w_ext;
        br_q    <= bus.br_en_in;
        mis_q   <= w_misalign;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.data_addr    = {bus.alu_in[XLEN-1:2], 2'b00};
  assign bus.data_wdata   = w_wdata;
  assign bus.data_mbe     = w_mbe;
  assign bus.data_read    = w_rd;
  assign bus.data_write   = w_wr;
  assign bus.stall_out    = w_stall;
  assign bus.out_valid    = valid_q;
  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4_out = pc4_q;
  assign bus.instr_out    = instr_q;
  assign bus.ctrl_out     = ctrl_q;
  assign bus.alu_out      = alu_q;
  assign bus.rdata_out    = rdata_q;
  assign bus.br_en_out    = {{(XLEN-1){1'b0}}, br_q};
  assign bus.misalign_out = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_hs
//  Purpose  : Self-checking bench for mem_stage_hs. Directed scenarios plus
//             randomized loads/stores/ALU ops with random memory latency and
//             WB back-pressure, checked against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_hs;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_hs_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

`ifdef MEM_STAGE_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_stage_hs #(
    .XLEN    (XLEN),
    .MBE_W   (XLEN/8),
    .CTRL_W  (CTRL_W),
    .TMO_CYC (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ov;                         // model of the last registered out_valid
  logic [2:0] ld_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic m_misalign(input logic mem, input logic [2:0] f3, input logic [31:0] a);
    if (!mem) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    int sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = 8 * int'(a[1:0]);
        v  = (d >> sh) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        sh = 16 * int'(a[1]);
        v  = (d >> sh) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_mbe(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'b0000;
    case (f3)
      3'b000:  return 4'(1 << a[1:0]);
      3'b001:  return 4'(3 << a[1:0]);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    case (f3)
      3'b000:  return b * 32'h0101_0101;
      3'b001:  return h * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic set_idle();
    bus.in_valid     = 1'b0;
    bus.mem_read_in  = 1'b0;
    bus.mem_write_in = 1'b0;
    bus.data_resp    = 1'b0;
    bus.stall_in     = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ov"},    bus.out_valid,    0);
    check_eq({tag, "_pc"},    bus.pc_out,       0);
    check_eq({tag, "_pc4"},   bus.pc_plus4_out, 0);
    check_eq({tag, "_instr"}, bus.instr_out,    0);
    check_eq({tag, "_ctrl"},  bus.ctrl_out,     0);
    check_eq({tag, "_alu"},   bus.alu_out,      0);
    check_eq({tag, "_rdata"}, bus.rdata_out,    0);
    check_eq({tag, "_br"},    bus.br_en_out,    0);
    check_eq({tag, "_mis"},   bus.misalign_out, 0);
  endtask

  // One instruction from presentation to retirement. lat = cycles before the
  // response arrives; hold = cycles of WB back-pressure starting with the
  // response cycle (or with the first cycle for non-memory instructions).
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rdata, input int lat, input int hold);
    logic [31:0] pc, instr, exp_rd;
    logic [63:0] ctrl;
    logic        br, mis, acc;
    pc     = $urandom;
    instr  = $urandom;
    ctrl   = {$urandom, $urandom};
    br     = 1'($urandom);
    mis    = m_misalign(rd | wr, f3, addr);
    acc    = (rd | wr) && !mis;
    exp_rd = (rd && acc) ? m_load(f3, addr, rdata) : 32'h0;

    bus.in_valid = 1'b1;  bus.pc_in = pc;  bus.instr_in = instr;  bus.ctrl_in = ctrl;
    bus.alu_in = addr;  bus.rs2_in = rs2;  bus.br_en_in = br;
    bus.mem_read_in = rd;  bus.mem_write_in = wr;  bus.funct3_in = f3;
    bus.data_resp = 1'b0;  bus.data_rdata = $urandom;  bus.stall_in = 1'b0;
    #1;
    check_eq("addr", bus.data_addr, addr & 32'hFFFF_FFFC);
    check_eq("mbe",  bus.data_mbe,  m_mbe(wr && acc, f3, addr));
    if (wr && acc) check_eq("wdata", bus.data_wdata, m_wdata(f3, rs2));

    if (acc) begin
      for (int k = 0; k < lat; k++) begin
        check_eq("wait_stall", bus.stall_out,  1);
        check_eq("wait_rd",    bus.data_read,  rd);
        check_eq("wait_wr",    bus.data_write, wr);
        tick();
        check_eq("bubble", bus.out_valid, 0);
        exp_ov = 1'b0;
        bus.data_rdata = $urandom;
        #1;
      end
      bus.data_resp  = 1'b1;
      bus.data_rdata = rdata;
      bus.stall_in   = (hold > 0);
      #1;
      check_eq("resp_stall", bus.stall_out, hold > 0);
      check_eq("resp_rd",    bus.data_read, rd);
      if (hold > 0) begin
        tick();
        check_eq("hold_ov", bus.out_valid, exp_ov);
        bus.data_resp  = 1'b0;
        bus.data_rdata = ~rdata;
        for (int h = 1; h < hold; h++) begin
          #1;
          check_eq("hold_stall", bus.stall_out, 1);
          check_eq("hold_rd",    bus.data_read, 0);
          tick();
          check_eq("hold_ov", bus.out_valid, exp_ov);
        end
        bus.stall_in = 1'b0;
        #1;
        check_eq("release_stall", bus.stall_out, 0);
        check_eq("release_rd",    bus.data_read, 0);
      end
    end else begin
      check_eq("noacc_rd",    bus.data_read,  0);
      check_eq("noacc_wr",    bus.data_write, 0);
      check_eq("noacc_stall", bus.stall_out,  0);
      for (int h = 0; h < hold; h++) begin
        bus.stall_in = 1'b1;
        #1;
        check_eq("bp_stall", bus.stall_out, 1);
        tick();
        check_eq("bp_ov", bus.out_valid, exp_ov);
      end
      bus.stall_in = 1'b0;
    end

    tick();
    bus.data_resp = 1'b0;
    check_eq("ret_ov",    bus.out_valid,    1);
    check_eq("ret_rdata", bus.rdata_out,    exp_rd);
    check_eq("ret_mis",   bus.misalign_out, mis);
    check_eq("ret_pc",    bus.pc_out,       pc);
    check_eq("ret_pc4",   bus.pc_plus4_out, pc + 32'd4);
    check_eq("ret_instr", bus.instr_out,    instr);
    check_eq("ret_ctrl",  bus.ctrl_out,     ctrl);
    check_eq("ret_alu",   bus.alu_out,      addr);
    check_eq("ret_br",    bus.br_en_out,    {31'b0, br});
    exp_ov = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    int          sel, lat, hold;

    // ------------------------------------------------ reset with a live request
    exp_ov = 1'b0;
    rst_n  = 1'b0;
    set_idle();
    bus.in_valid = 1'b1;  bus.mem_read_in = 1'b1;  bus.funct3_in = 3'b010;
    bus.alu_in = 32'h100;  bus.pc_in = 32'h40;  bus.instr_in = 32'h1;
    bus.ctrl_in = 64'h5;  bus.rs2_in = 32'h7;  bus.br_en_in = 1'b1;
    bus.data_rdata = 32'h55;
    #1;
    check_eq("por_rd", bus.data_read, 0);
    tick();
    tick();
    check_zero_outputs("por");
    set_idle();
    rst_n = 1'b1;

    // ------------------------------------------------ directed scenarios
    do_op(1, 0, 3'b010, 32'h100, 32'h0,  32'hDEAD_BEEF, 0, 0); // LW zero-wait
    do_op(1, 0, 3'b000, 32'h103, 32'h0,  32'h80FF_0000, 3, 0); // LB 3 bubbles
    do_op(1, 0, 3'b101, 32'h102, 32'h0,  32'h8001_1234, 1, 0); // LHU
    do_op(0, 1, 3'b000, 32'h101, 32'hAB, 32'h0,         2, 0); // SB lane 1
    do_op(0, 1, 3'b001, 32'h102, 32'h1234_5678, 32'h0,  0, 0); // SH upper half
    do_op(1, 0, 3'b010, 32'h102, 32'h0,  32'h1234_5678, 2, 0); // misaligned LW
    do_op(1, 0, 3'b010, 32'h200, 32'h0,  32'hCAFE_F00D, 1, 2); // HOLD 2 cycles
    do_op(1, 0, 3'b001, 32'h202, 32'h0,  32'h8000_7FFF, 0, 1); // LH, HOLD
    do_op(0, 0, 3'b000, 32'h0,   32'h0,  32'h0,         0, 2); // ALU op, back-pressure

    // ------------------------------------------------ reset while in WAIT
    bus.in_valid = 1'b1;  bus.mem_read_in = 1'b1;  bus.mem_write_in = 1'b0;
    bus.funct3_in = 3'b010;  bus.alu_in = 32'h300;  bus.data_resp = 1'b0;
    #1;
    check_eq("rw_rd_before", bus.data_read, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rw_rd_drop", bus.data_read, 0);
    tick();
    check_zero_outputs("rw");
    set_idle();
    rst_n  = 1'b1;
    exp_ov = 1'b0;

    // ------------------------------------------------ reset while in HOLD
    bus.in_valid = 1'b1;  bus.mem_read_in = 1'b1;  bus.funct3_in = 3'b010;
    bus.alu_in = 32'h400;  bus.data_resp = 1'b1;  bus.stall_in = 1'b1;
    bus.data_rdata = 32'h1111_2222;
    tick();
    rst_n = 1'b0;
    set_idle();
    tick();
    check_zero_outputs("rh");
    rst_n = 1'b1;
    do_op(1, 0, 3'b010, 32'h404, 32'h0, 32'h3333_4444, 0, 0);

    // ------------------------------------------------ randomized traffic
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        set_idle();
        tick();
        check_eq("idle_ov", bus.out_valid, 0);
        exp_ov = 1'b0;
      end else begin
        sel  = $urandom_range(0, 2);
        rd   = (sel == 1);
        wr   = (sel == 2);
        f3   = wr ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
        lat  = $urandom_range(0, 3);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        do_op(rd, wr, f3, $urandom, $urandom, $urandom, lat, hold);
      end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // ------------------------------------------------ watchdog expiry
    begin
      int   cyc;
      logic seen;
      set_idle();
      bus.in_valid = 1'b1;  bus.mem_read_in = 1'b1;  bus.funct3_in = 3'b010;
      bus.alu_in = 32'h500;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 400) begin
        tick();
        cyc++;
        seen = bus.out_valid;
      end
      bus.in_valid = 1'b0;
      check_eq("tmo_retire", seen, 1);
      check_eq("tmo_err",    timeout_err, 1);
      check_eq("tmo_rdata",  bus.rdata_out, 0);
      rst_n = 1'b0;
      tick();
      check_eq("tmo_clear", timeout_err, 0);
      rst_n = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
